// File: rtl/mac_divide_sequencer_if.sv
// Bundle between the MAC/divide sequencer and its neighbours.
// Carries the term input, the divider link, the result output and the status flags.
interface mac_divide_sequencer_if;
  logic        IN_VALID;
  logic        IN_READY;
  logic [15:0] IN_DATA;
  logic [15:0] IN_WEIGHT;
  logic [15:0] SCALE;
  logic [31:0] DIV_TOP;
  logic [31:0] DIV_DIVISOR;
  logic        DIV_START;
  logic        DIV_FINISH;
  logic [31:0] DIV_QUOTIENT;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] OUT_DATA;
  logic        BUSY;
  logic        ERR_DIV0;
  logic        ERR_TIMEOUT;

  modport slave (
    input  IN_VALID, IN_DATA, IN_WEIGHT, SCALE,
    input  DIV_FINISH, DIV_QUOTIENT, OUT_READY,
    output IN_READY, DIV_TOP, DIV_DIVISOR, DIV_START,
    output OUT_VALID, OUT_DATA, BUSY, ERR_DIV0, ERR_TIMEOUT
  );

  modport master (
    output IN_VALID, IN_DATA, IN_WEIGHT, SCALE,
    output DIV_FINISH, DIV_QUOTIENT, OUT_READY,
    input  IN_READY, DIV_TOP, DIV_DIVISOR, DIV_START,
    input  OUT_VALID, OUT_DATA, BUSY, ERR_DIV0, ERR_TIMEOUT
  );
endinterface

// File: rtl/mac_divide_sequencer.sv
// Saturating MAC over NUM_TERMS pairs, then one divide by SCALE.
// Ports: CLOCK, RESET_N (async low), bus (slave side). Option: MAC_DIV_RELU_EN.
module mac_divide_sequencer #(
  parameter int NUM_TERMS      = 8,
  parameter int TIMEOUT_CYCLES = 40
) (
  input logic                   CLOCK,
  input logic                   RESET_N,
  mac_divide_sequencer_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [31:0] POS_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] NEG_MAX = 32'h8000_0001;

  typedef enum logic [2:0] {
    S_IDLE, S_ACCUM, S_LAUNCH, S_WAIT, S_OUTPUT
  } state_t;

  state_t        state_q;
  logic [31:0]   acc_q;
  logic [31:0]   div_top_q;
  logic [31:0]   div_dvs_q;
  logic [31:0]   out_data_q;
  logic [15:0]   scale_q;
  logic [7:0]    count_q;
  logic [TW-1:0] timer_q;
  logic          in_ready_q;
  logic          div_start_q;
  logic          out_valid_q;
  logic          busy_q;
  logic          err_div0_q;
  logic          err_to_q;

  logic signed [15:0] din;
  logic signed [15:0] win;
  logic signed [15:0] scale_now;
  logic signed [31:0] prod;
  logic signed [31:0] base;
  logic signed [32:0] sum;
  logic [31:0]        acc_sat;
  logic               accept;
  logic               last;

  function automatic logic [31:0] shape(input logic [31:0] v);
`ifdef MAC_DIV_RELU_EN
    shape = v[31] ? 32'h0 : v;
`else
    shape = v;
`endif
  endfunction

  assign din       = bus.IN_DATA;
  assign win       = bus.IN_WEIGHT;
  assign scale_now = (state_q == S_IDLE) ? bus.SCALE : scale_q;
  assign prod      = 32'(din) * 32'(win);
  assign base      = (state_q == S_IDLE) ? '0 : acc_q;
  assign sum       = 33'(base) + 33'(prod);
  assign accept    = bus.IN_VALID && in_ready_q;
  assign last      = (state_q == S_IDLE) ? (NUM_TERMS == 1)
                   : (count_q == 8'(NUM_TERMS - 1));

  // Clamp symmetric: -2^31 would overflow when the divider negates it.
  always_comb begin
    acc_sat = sum[31:0];
    if (sum > 33'sd2147483647)
      acc_sat = POS_MAX;
    else if (sum < -33'sd2147483647)
      acc_sat = NEG_MAX;
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      div_top_q   <= '0;
      div_dvs_q   <= '0;
      out_data_q  <= '0;
      scale_q     <= '0;
      count_q     <= '0;
      timer_q     <= '0;
      in_ready_q  <= 1'b0;
      div_start_q <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      err_div0_q  <= 1'b0;
      err_to_q    <= 1'b0;
    end else begin
      div_start_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_ACCUM: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            acc_q   <= acc_sat;
            busy_q  <= 1'b1;
            state_q <= S_ACCUM;
            count_q <= (state_q == S_IDLE) ? 8'd1 : count_q + 8'd1;
            if (state_q == S_IDLE)
              scale_q <= bus.SCALE;
            if (last) begin
              state_q    <= S_LAUNCH;
              in_ready_q <= 1'b0;
              // Operands land with the pulse and hold to the next launch.
              if (scale_now != 16'sd0) begin
                div_top_q   <= acc_sat;
                div_dvs_q   <= 32'(scale_now);
                div_start_q <= 1'b1;
              end
            end
          end
        end
        S_LAUNCH: begin
          timer_q <= '0;
          if (scale_q == 16'h0) begin
            out_data_q  <= shape(acc_q[31] ? NEG_MAX : POS_MAX);
            err_div0_q  <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= S_OUTPUT;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.DIV_FINISH) begin
            out_data_q  <= shape(bus.DIV_QUOTIENT);
            out_valid_q <= 1'b1;
            state_q     <= S_OUTPUT;
          end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
            out_data_q  <= shape(32'h0);
            err_to_q    <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= S_OUTPUT;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_OUTPUT: begin
          if (bus.OUT_READY) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.IN_READY    = in_ready_q;
  assign bus.DIV_TOP     = div_top_q;
  assign bus.DIV_DIVISOR = div_dvs_q;
  assign bus.DIV_START   = div_start_q;
  assign bus.OUT_VALID   = out_valid_q;
  assign bus.OUT_DATA    = out_data_q;
  assign bus.BUSY        = busy_q;
  assign bus.ERR_DIV0    = err_div0_q;
  assign bus.ERR_TIMEOUT = err_to_q;
endmodule

// File: tb/tb_mac_divide_sequencer.sv
// Bench for mac_divide_sequencer: directed table, corner sequences,
// random groups against an arithmetic reference, divider model.
module tb_mac_divide_sequencer;
  localparam int NT = 4;
  localparam int TO = 40;
  localparam longint MAXV = 64'sd2147483647;
  // Edges after the accepting edge until OUT_VALID is seen.
  localparam int DIV0_LAT = 1;
  localparam int TO_LAT   = TO + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mac_divide_sequencer_if bus();

  mac_divide_sequencer #(
    .NUM_TERMS(NT),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLOCK(clk),
    .RESET_N(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Divider model: samples START on negedge, finishes div_lat
  // negedges later, holds FINISH high until the next START.
  int          div_lat = 3;
  bit          div_dead = 1'b0;
  int          div_cnt = -1;
  int          div_starts = 0;
  logic        div_fin = 1'b0;
  logic [31:0] div_q = '0;
  logic [31:0] q_pend = '0;

  assign bus.DIV_FINISH   = div_fin;
  assign bus.DIV_QUOTIENT = div_q;

  always @(negedge clk) begin
    if (bus.DIV_START === 1'b1) begin
      div_starts <= div_starts + 1;
      div_fin    <= 1'b0;
      q_pend     <= $signed(bus.DIV_TOP) / $signed(bus.DIV_DIVISOR);
      div_cnt    <= div_dead ? -1 : div_lat;
    end else if (div_cnt > 0) begin
      div_cnt <= div_cnt - 1;
    end else if (div_cnt == 0) begin
      div_fin <= 1'b1;
      div_q   <= q_pend;
      div_cnt <= -1;
    end
  end

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] relu_tb(input logic [31:0] v);
`ifdef MAC_DIV_RELU_EN
    return v[31] ? 32'h0 : v;
`else
    return v;
`endif
  endfunction

  function automatic longint ref_sum(input logic [NT-1:0][15:0] d,
                                     input logic [NT-1:0][15:0] w);
    longint a = 0;
    for (int i = 0; i < NT; i++) begin
      a += longint'($signed(d[i])) * longint'($signed(w[i]));
      if (a > MAXV) a = MAXV;
      if (a < -MAXV) a = -MAXV;
    end
    return a;
  endfunction

  function automatic logic [31:0] ref_out(input longint s,
                                          input logic [15:0] sc);
    longint q;
    if (sc == 16'h0) q = (s >= 0) ? MAXV : -MAXV;
    else q = s / longint'($signed(sc));
    return relu_tb(32'(q));
  endfunction

  task automatic send(input logic [NT-1:0][15:0] d,
                      input logic [NT-1:0][15:0] w,
                      input logic [15:0] sc);
    for (int i = 0; i < NT; i++) begin
      int  g;
      int  guard;
      bit  done;
      g = $urandom_range(0, 2);
      repeat (g) begin @(posedge clk); #1; end
      bus.IN_VALID  = 1'b1;
      bus.IN_DATA   = d[i];
      bus.IN_WEIGHT = w[i];
      bus.SCALE     = (i == 0) ? sc : 16'($urandom);
      guard = 0;
      done  = 1'b0;
      while (!done && guard < 50) begin
        done = bus.IN_READY;
        @(posedge clk); #1;
        guard++;
      end
      check("term accept", 32'(done), 32'd1);
      bus.IN_VALID = 1'b0;
      bus.IN_DATA  = 16'($urandom);
    end
  endtask

  task automatic run_group(input string nm,
                           input logic [NT-1:0][15:0] d,
                           input logic [NT-1:0][15:0] w,
                           input logic [15:0] sc,
                           input logic [31:0] exp_out,
                           input logic [31:0] exp_top,
                           input int exp_lat,
                           input int hold);
    int s0;
    int lat;
    s0 = div_starts;
    send(d, w, sc);
    lat = 0;
    while (bus.OUT_VALID !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({nm, " out_valid"}, 32'(bus.OUT_VALID), 32'd1);
    if (exp_lat >= 0)
      check({nm, " latency"}, lat, exp_lat);
    check({nm, " out_data"}, bus.OUT_DATA, exp_out);
    check({nm, " starts"}, div_starts - s0, (sc != 0) ? 1 : 0);
    if (sc != 16'h0) begin
      check({nm, " div_top"}, bus.DIV_TOP, exp_top);
      check({nm, " divisor"}, bus.DIV_DIVISOR,
            32'($signed(sc)));
    end
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check({nm, " hold valid"}, 32'(bus.OUT_VALID), 32'd1);
      check({nm, " hold data"}, bus.OUT_DATA, exp_out);
      check({nm, " hold in_ready"}, 32'(bus.IN_READY), 32'd0);
    end
    bus.OUT_READY = 1'b1;
    @(posedge clk); #1;
    bus.OUT_READY = 1'b0;
    check({nm, " valid drop"}, 32'(bus.OUT_VALID), 32'd0);
    check({nm, " idle"}, 32'(bus.BUSY), 32'd0);
  endtask

  typedef struct {
    string              nm;
    logic [NT-1:0][15:0] d;
    logic [NT-1:0][15:0] w;
    logic [15:0]        sc;
    logic [31:0]        top;
    logic [31:0]        out;
    int                 lat;
    int                 hold;
  } vec_t;

  vec_t vt[5];

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [NT-1:0][15:0] d;
    logic [NT-1:0][15:0] w;
    logic [15:0] sc;
    longint s;
    int seen;

    vt[0] = '{"pos", {16'd400, 16'd300, 16'd200, 16'd100},
              {4{16'd1}}, 16'd10, 32'd1000, 32'd100, -1, 5};
    vt[1] = '{"neg", {4{-16'sd50}}, {4{16'd2}}, 16'd4,
              32'hFFFF_FE70, relu_tb(32'hFFFF_FF9C), -1, 0};
    vt[2] = '{"satp", {4{16'd32767}}, {4{16'd32767}}, 16'd1,
              32'h7FFF_FFFF, 32'h7FFF_FFFF, -1, 1};
    vt[3] = '{"satn", {4{16'h8000}}, {4{16'd32767}}, 16'd1,
              32'h8000_0001, relu_tb(32'h8000_0001), -1, 0};
    vt[4] = '{"div0", {4{16'd5}}, {4{16'd1}}, 16'd0,
              32'h0, 32'h7FFF_FFFF, DIV0_LAT, 2};

    bus.IN_VALID  = 1'b0;
    bus.IN_DATA   = '0;
    bus.IN_WEIGHT = '0;
    bus.SCALE     = '0;
    bus.OUT_READY = 1'b0;

    #2 rst_n = 1'b0;
    #1;
    check("rst in_ready", 32'(bus.IN_READY), 32'd0);
    check("rst out_valid", 32'(bus.OUT_VALID), 32'd0);
    check("rst busy", 32'(bus.BUSY), 32'd0);
    check("rst start", 32'(bus.DIV_START), 32'd0);
    check("rst out_data", bus.OUT_DATA, 32'd0);
    check("rst div_top", bus.DIV_TOP, 32'd0);
    check("rst errs", {30'd0, bus.ERR_DIV0, bus.ERR_TIMEOUT}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel in_ready pre", 32'(bus.IN_READY), 32'd0);
    @(posedge clk); #1;
    check("rel in_ready", 32'(bus.IN_READY), 32'd1);

    for (int i = 0; i < 5; i++)
      run_group(vt[i].nm, vt[i].d, vt[i].w, vt[i].sc,
                vt[i].out, vt[i].top, vt[i].lat, vt[i].hold);
    check("err_div0 set", 32'(bus.ERR_DIV0), 32'd1);
    check("err_to clear", 32'(bus.ERR_TIMEOUT), 32'd0);

    div_dead = 1'b1;
    run_group("timeout", {4{16'd5}}, {4{16'd1}}, 16'd1,
              relu_tb(32'h0), 32'd20, TO_LAT, 0);
    check("err_to set", 32'(bus.ERR_TIMEOUT), 32'd1);
    div_dead = 1'b0;
    run_group("recover", {4{16'd6}}, {4{16'd3}}, 16'hFFFD,
              relu_tb(32'hFFFF_FFE8), 32'd72, -1, 0);
    check("err_div0 sticky", 32'(bus.ERR_DIV0), 32'd1);

    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < NT; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          d[i] = ($urandom_range(0, 1) == 1) ? 16'h7FFF : 16'h8000;
          w[i] = ($urandom_range(0, 1) == 1) ? 16'h7FFF : 16'h8000;
        end else begin
          d[i] = 16'($urandom);
          w[i] = 16'($urandom);
        end
      end
      case ($urandom_range(0, 7))
        0:       sc = 16'h0;
        1, 2:    sc = 16'($urandom);
        default: sc = 16'($urandom_range(1, 300));
      endcase
      div_lat = $urandom_range(1, 6);
      s = ref_sum(d, w);
      run_group("rand", d, w, sc, ref_out(s, sc), 32'(s),
                (sc == 0) ? DIV0_LAT : -1, $urandom_range(0, 3));
    end

    div_lat = 12;
    send({4{16'd7}}, {4{16'd1}}, 16'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid busy", 32'(bus.BUSY), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid rst busy", 32'(bus.BUSY), 32'd0);
    check("mid rst in_ready", 32'(bus.IN_READY), 32'd0);
    check("mid rst valid", 32'(bus.OUT_VALID), 32'd0);
    check("mid rst errs", {30'd0, bus.ERR_DIV0, bus.ERR_TIMEOUT},
          32'd0);
    check("mid rst div_top", bus.DIV_TOP, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (bus.OUT_VALID === 1'b1) seen++;
    end
    check("stale finish ignored", seen, 0);
    check("post rst idle", 32'(bus.BUSY), 32'd0);
    check("post rst in_ready", 32'(bus.IN_READY), 32'd1);

    div_lat = 2;
    run_group("final", {16'd1, 16'd2, 16'd3, 16'd4}, {4{16'd10}},
              16'd5, 32'd20, 32'd100, -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
